// File: rtl/dff_response_checker.sv
// Cycle-accurate checker for a single-bit DFF: reference model, settle FSM, saturating counters, first-error capture.
// Results are registered 1 cycle after the sampling edge; define DFF_CHK_QBAR_EN to compile in the qbar complement check.
module dff_response_checker #(
  parameter int CNT_W  = 8,
  parameter int SETTLE = 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_en,
  input  logic             i_d_obs,
  input  logic             i_dut_rst_obs,
  input  logic             i_q_obs,
  input  logic             i_qbar_obs,
  output logic             o_err_pulse,
  output logic             o_fail,
  output logic [CNT_W-1:0] o_checks,
  output logic [CNT_W-1:0] o_errors,
  output logic [CNT_W-1:0] o_first_err_idx,
  output logic [1:0]       o_first_err_code,
  output logic [1:0]       o_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SYNC  = 2'b01,
    CHECK = 2'b10
  } state_t;

  localparam logic [3:0]       LP_SETTLE = 4'(SETTLE);
  localparam logic [CNT_W-1:0] LP_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           r_state;
  state_t           w_state_nxt;
  logic [3:0]       r_settle_cnt;
  logic [3:0]       w_settle_nxt;
  logic             r_exp_q;
  logic             r_err_pulse;
  logic             r_fail;
  logic [CNT_W-1:0] r_checks;
  logic [CNT_W-1:0] r_errors;
  logic [CNT_W-1:0] r_first_err_idx;
  logic [1:0]       r_first_err_code;
  logic             w_cmp;
  logic             w_qm;
  logic             w_cv;
  logic             w_mis;

  assign w_qm = (i_q_obs != r_exp_q);

`ifdef DFF_CHK_QBAR_EN
  assign w_cv = (i_qbar_obs != ~i_q_obs);
`else
  // Single-output DUT: qbar is not observed at all.
  logic w_unused_qbar;
  assign w_cv          = 1'b0;
  assign w_unused_qbar = i_qbar_obs;
`endif

  assign w_mis = w_qm | w_cv;

  always_comb begin
    w_state_nxt  = r_state;
    w_settle_nxt = r_settle_cnt;
    w_cmp        = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_en) begin
          w_state_nxt  = SYNC;
          w_settle_nxt = LP_SETTLE;
        end
      end
      SYNC: begin
        if (!i_en) begin
          w_state_nxt = IDLE;
        end else if (r_settle_cnt <= 4'd1) begin
          w_state_nxt = CHECK;
        end else begin
          w_settle_nxt = r_settle_cnt - 4'd1;
        end
      end
      CHECK: begin
        // The cycle in which en drops only leaves CHECK; it is not compared.
        if (!i_en) begin
          w_state_nxt = IDLE;
        end else begin
          w_cmp = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state          <= IDLE;
      r_settle_cnt     <= 4'd0;
      r_exp_q          <= 1'b0;
      r_err_pulse      <= 1'b0;
      r_fail           <= 1'b0;
      r_checks         <= '0;
      r_errors         <= '0;
      r_first_err_idx  <= '0;
      r_first_err_code <= 2'b00;
    end else begin
      r_state      <= w_state_nxt;
      r_settle_cnt <= w_settle_nxt;
      r_exp_q      <= i_dut_rst_obs ? 1'b0 : i_d_obs;
      r_err_pulse  <= w_cmp & w_mis;
      if (w_cmp) begin
        if (!(&r_checks)) r_checks <= r_checks + LP_ONE;
        if (w_mis) begin
          if (!(&r_errors)) r_errors <= r_errors + LP_ONE;
          // First-error capture uses checks before this compare's increment.
          if (!r_fail) begin
            r_fail           <= 1'b1;
            r_first_err_idx  <= r_checks;
            r_first_err_code <= {w_cv, w_qm};
          end
        end
      end
    end
  end

  assign o_err_pulse      = r_err_pulse;
  assign o_fail           = r_fail;
  assign o_checks         = r_checks;
  assign o_errors         = r_errors;
  assign o_first_err_idx  = r_first_err_idx;
  assign o_first_err_code = r_first_err_code;
  assign o_state          = r_state;

endmodule
